// File: rtl/nf_out_merge_avlstrm_if.sv
// Avalon-ST style packet stream bundle: data beat plus valid/ready handshake
// and sop/eop/empty framing. tx drives the beat, rx returns ready.
interface avl_stream_if #(
  parameter int WIDTH   = 512,
  parameter int EMPTY_W = 6
);
  logic [WIDTH-1:0]   data;
  logic               valid;
  logic               ready;
  logic               sop;
  logic               eop;
  logic [EMPTY_W-1:0] empty;

  modport tx (output data, valid, sop, eop, empty, input ready);
  modport rx (input data, valid, sop, eop, empty, output ready);
endinterface

// File: rtl/nf_out_merge_avlstrm.sv
// Packet-granular round-robin merge of the no-check (in0) and checked (in1)
// streams into one egress stream, with a 2-entry output buffer and stats.
module nf_out_merge_avlstrm #(
  parameter int WIDTH   = 512,
  parameter int EMPTY_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  avl_stream_if.rx    in0,
  avl_stream_if.rx    in1,
  avl_stream_if.tx    out,
  output logic        out_src,
  output logic [31:0] stats_in0_pkt,
  output logic [31:0] stats_in1_pkt,
  output logic [31:0] stats_out_pkt,
  output logic [31:0] stats_err_beat
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic               src;
  } beat_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  beat_t       mem_q [2];
  beat_t       mem_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] stats_in0_pkt_q, stats_in0_pkt_d;
  logic [31:0] stats_in1_pkt_q, stats_in1_pkt_d;
  logic [31:0] stats_out_pkt_q, stats_out_pkt_d;
  logic [31:0] stats_err_beat_q, stats_err_beat_d;

  logic  full, cand0, cand1, win, drop0, drop1;
  logic  rdy0, rdy1, push, pop;
  logic  [1:0] err_inc;
  beat_t in0_beat, in1_beat, push_beat, head;

  assign full     = (count_q == 2'd2);
  assign cand0    = in0.valid & in0.sop;
  assign cand1    = in1.valid & in1.sop;
  assign drop0    = in0.valid & ~in0.sop;
  assign drop1    = in1.valid & ~in1.sop;
  // Under contention the input not granted last time wins.
  assign win      = (cand0 & cand1) ? ~last_grant_q : cand1;
  assign in0_beat = {in0.data, in0.sop, in0.eop, in0.empty, 1'b0};
  assign in1_beat = {in1.data, in1.sop, in1.eop, in1.empty, 1'b1};
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    mem_d            = mem_q;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    rdy0             = 1'b0;
    rdy1             = 1'b0;
    push             = 1'b0;
    push_beat        = in0_beat;
    err_inc          = 2'd0;

    case (state_q)
      IDLE: begin
        if (cand0 | cand1) begin
          push      = ~full;
          push_beat = win ? in1_beat : in0_beat;
          if (win) rdy1 = ~full;
          else     rdy0 = ~full;
          if (!full) begin
            last_grant_d = win;
            if (!push_beat.eop) state_d = win ? LOCK1 : LOCK0;
          end
        end
        // Headless beats outside a packet are swallowed so they cannot stall the arbiter.
        if (drop0) rdy0 = 1'b1;
        if (drop1) rdy1 = 1'b1;
        err_inc = {1'b0, drop0} + {1'b0, drop1};
      end
      LOCK0: begin
        rdy0      = ~full;
        push      = in0.valid & ~full;
        push_beat = in0_beat;
        if (push) begin
          if (in0.eop) state_d = IDLE;
          if (in0.sop) err_inc = 2'd1;
        end
      end
      LOCK1: begin
        rdy1      = ~full;
        push      = in1.valid & ~full;
        push_beat = in1_beat;
        if (push) begin
          if (in1.eop) state_d = IDLE;
          if (in1.sop) err_inc = 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    pop = (count_q != 2'd0) & out.ready;
    if (push) begin
      mem_d[wr_ptr_q] = push_beat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};

    stats_in0_pkt_d  = stats_in0_pkt_q + {31'd0, in0.valid & rdy0 & in0.eop};
    stats_in1_pkt_d  = stats_in1_pkt_q + {31'd0, in1.valid & rdy1 & in1.eop};
    stats_out_pkt_d  = stats_out_pkt_q + {31'd0, pop & head.eop};
    stats_err_beat_d = stats_err_beat_q + {30'd0, err_inc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      last_grant_q     <= 1'b1;
      mem_q[0]         <= '0;
      mem_q[1]         <= '0;
      rd_ptr_q         <= 1'b0;
      wr_ptr_q         <= 1'b0;
      count_q          <= 2'd0;
      stats_in0_pkt_q  <= 32'd0;
      stats_in1_pkt_q  <= 32'd0;
      stats_out_pkt_q  <= 32'd0;
      stats_err_beat_q <= 32'd0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      mem_q            <= mem_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
      stats_in0_pkt_q  <= stats_in0_pkt_d;
      stats_in1_pkt_q  <= stats_in1_pkt_d;
      stats_out_pkt_q  <= stats_out_pkt_d;
      stats_err_beat_q <= stats_err_beat_d;
    end
  end

  assign in0.ready      = rdy0;
  assign in1.ready      = rdy1;
  assign out.valid      = (count_q != 2'd0);
  assign out.data       = head.data;
  assign out.sop        = head.sop;
  assign out.eop        = head.eop;
  assign out.empty      = head.empty;
  assign out_src        = head.src;
  assign stats_in0_pkt  = stats_in0_pkt_q;
  assign stats_in1_pkt  = stats_in1_pkt_q;
  assign stats_out_pkt  = stats_out_pkt_q;
  assign stats_err_beat = stats_err_beat_q;

endmodule

// File: tb/tb_nf_out_merge_avlstrm.sv
// Scoreboard bench for nf_out_merge_avlstrm: directed scenarios plus random
// traffic, checked against a packet-level reference model.
module tb_nf_out_merge_avlstrm;
  localparam int W  = 512;
  localparam int EW = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_src;
  logic [31:0] s_in0, s_in1, s_out, s_err;

  always #5 clk = ~clk;

  avl_stream_if #(.WIDTH(W), .EMPTY_W(EW)) i0 ();
  avl_stream_if #(.WIDTH(W), .EMPTY_W(EW)) i1 ();
  avl_stream_if #(.WIDTH(W), .EMPTY_W(EW)) o ();

  nf_out_merge_avlstrm #(.WIDTH(W), .EMPTY_W(EW)) dut (
    .clk(clk), .rst(rst), .in0(i0), .in1(i1), .out(o), .out_src(out_src),
    .stats_in0_pkt(s_in0), .stats_in1_pkt(s_in1),
    .stats_out_pkt(s_out), .stats_err_beat(s_err)
  );

  typedef struct {
    logic [W-1:0]  data;
    bit            sop;
    bit            eop;
    logic [EW-1:0] empty;
    bit            src;
  } beat_t;

  beat_t q0[$], q1[$], exp_q[$], mbuf[$];
  bit    pres0, pres1;
  int    checks = 0, errors = 0;
  int    owner, last;
  logic [31:0] m_in0, m_in1, m_out, m_err;
  int    gap_pct = 0, ready_pct = 100;
  int    cyc = 0;
  int    src_log[$], cyc_log[$];

  task automatic checkOutput(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_data();
    logic [W-1:0] d;
    for (int k = 0; k < W/32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic beat_t mkbeat(bit s, bit e, logic [EW-1:0] emp, bit src);
    beat_t b;
    b.data = rnd_data(); b.sop = s; b.eop = e; b.empty = emp; b.src = src;
    return b;
  endfunction

  task automatic push_src(bit src, beat_t b);
    if (src) q1.push_back(b); else q0.push_back(b);
  endtask

  // A packet of len beats; with allow_err a middle beat may carry a stray sop.
  task automatic add_pkt(bit src, int len, bit allow_err, int emp);
    for (int k = 0; k < len; k++) begin
      bit s = (k == 0) || (allow_err && k < len-1 && $urandom_range(0, 7) == 0);
      bit e = (k == len-1);
      push_src(src, mkbeat(s, e, e ? EW'(emp) : '0, src));
    end
  endtask

  task automatic add_stray(bit src);
    push_src(src, mkbeat(1'b0, 1'b0, '0, src));
  endtask

  task automatic model_reset();
    owner = -1; last = 1;
    m_in0 = 0; m_in1 = 0; m_out = 0; m_err = 0;
    exp_q.delete(); mbuf.delete(); q0.delete(); q1.delete();
    pres0 = 0; pres1 = 0;
    i0.valid = 0; i0.sop = 0; i0.eop = 0; i0.empty = '0; i0.data = '0;
    i1.valid = 0; i1.sop = 0; i1.eop = 0; i1.empty = '0; i1.data = '0;
  endtask

  // Packet-level reference: who may transfer this cycle, what leaves the buffer.
  task automatic model_step();
    bit full = (mbuf.size() == 2);
    bit v0 = pres0, v1 = pres1;
    bit s0 = pres0 && q0[0].sop;
    bit s1 = pres1 && q1[0].sop;
    bit r0 = 0, r1 = 0, f0 = 0, f1 = 0;
    int err_add = 0;
    beat_t b;
    if (owner < 0) begin
      int win = -1;
      if (v0 && s0 && v1 && s1) win = (last == 0) ? 1 : 0;
      else if (v0 && s0)       win = 0;
      else if (v1 && s1)       win = 1;
      if (win == 0) begin r0 = !full; f0 = r0; end
      if (win == 1) begin r1 = !full; f1 = r1; end
      if (v0 && !s0) begin r0 = 1; err_add++; end
      if (v1 && !s1) begin r1 = 1; err_add++; end
    end else if (owner == 0) begin
      r0 = !full; f0 = v0 && r0;
      if (f0 && s0) err_add++;
    end else begin
      r1 = !full; f1 = v1 && r1;
      if (f1 && s1) err_add++;
    end

    checkOutput("in0_ready", W'(i0.ready), W'(r0));
    checkOutput("in1_ready", W'(i1.ready), W'(r1));
    checkOutput("out_valid", W'(o.valid), W'(mbuf.size() != 0));
    checkOutput("stats_in0_pkt", W'(s_in0), W'(m_in0));
    checkOutput("stats_in1_pkt", W'(s_in1), W'(m_in1));
    checkOutput("stats_out_pkt", W'(s_out), W'(m_out));
    checkOutput("stats_err_beat", W'(s_err), W'(m_err));

    if (mbuf.size() != 0 && o.ready) begin
      b = mbuf.pop_front();
      if (b.eop) m_out++;
    end
    if (v0 && r0) begin
      b = q0.pop_front(); pres0 = 0;
      if (b.eop) m_in0++;
      if (f0) begin
        mbuf.push_back(b); exp_q.push_back(b);
        if (owner < 0) begin last = 0; if (!b.eop) owner = 0; end
        else if (b.eop) owner = -1;
      end
    end
    if (v1 && r1) begin
      b = q1.pop_front(); pres1 = 0;
      if (b.eop) m_in1++;
      if (f1) begin
        mbuf.push_back(b); exp_q.push_back(b);
        if (owner < 0) begin last = 1; if (!b.eop) owner = 1; end
        else if (b.eop) owner = -1;
      end
    end
    m_err += 32'(err_add);
  endtask

  // One cycle: drive at the falling edge, evaluate the model just after.
  task automatic applyStimulus();
    @(negedge clk);
    if (!pres0 && q0.size() > 0 && $urandom_range(0, 99) >= gap_pct) pres0 = 1;
    if (!pres1 && q1.size() > 0 && $urandom_range(0, 99) >= gap_pct) pres1 = 1;
    if (pres0) begin
      i0.valid = 1; i0.data = q0[0].data; i0.sop = q0[0].sop;
      i0.eop = q0[0].eop; i0.empty = q0[0].empty;
    end else begin
      i0.valid = 0; i0.sop = 0; i0.eop = 0; i0.empty = '0; i0.data = '0;
    end
    if (pres1) begin
      i1.valid = 1; i1.data = q1[0].data; i1.sop = q1[0].sop;
      i1.eop = q1[0].eop; i1.empty = q1[0].empty;
    end else begin
      i1.valid = 0; i1.sop = 0; i1.eop = 0; i1.empty = '0; i1.data = '0;
    end
    o.ready = ($urandom_range(0, 99) < ready_pct);
    #1;
    model_step();
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || pres0 || pres1 || mbuf.size() != 0) && n < 500) begin
      applyStimulus();
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("[TB] FAIL drain_timeout: %0d beats still pending, expected 0", mbuf.size() + q0.size() + q1.size());
    end
    repeat (2) applyStimulus();
  endtask

  task automatic do_reset();
    rst = 1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT transfers an output beat.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst && o.valid && o.ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL out_beat: unexpected beat src=%0d, expected none", out_src);
        end else begin
          e = exp_q.pop_front();
          if (o.data !== e.data || o.sop !== e.sop || o.eop !== e.eop ||
              o.empty !== e.empty || out_src !== e.src) begin
            errors++;
            $display("[TB] FAIL out_beat: got d=%h sop=%0d eop=%0d emp=%0d src=%0d, expected d=%h sop=%0d eop=%0d emp=%0d src=%0d",
                     o.data[31:0], o.sop, o.eop, o.empty, out_src,
                     e.data[31:0], e.sop, e.eop, e.empty, e.src);
          end
          src_log.push_back(int'(out_src));
          cyc_log.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1; o.ready = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_out_valid", W'(o.valid), '0);
    checkOutput("reset_out_src", W'(out_src), '0);
    checkOutput("reset_out_sop_eop", W'({o.sop, o.eop}), '0);
    checkOutput("reset_out_empty", W'(o.empty), '0);
    checkOutput("reset_out_data", o.data, '0);
    checkOutput("reset_stats", W'({s_in0, s_in1, s_out, s_err}), '0);
    @(negedge clk);
    rst = 0;

    // Single 3-beat in0 packet ending with empty=5.
    gap_pct = 0; ready_pct = 100;
    add_pkt(1'b0, 3, 1'b0, 5);
    drain();
    checkOutput("single_in0_pkt", W'(s_in0), W'(1));
    checkOutput("single_out_pkt", W'(s_out), W'(1));

    // Contention: both inputs offer 2-beat packets from the first cycle.
    do_reset();
    src_log.delete(); cyc_log.delete();
    for (int k = 0; k < 4; k++) begin
      add_pkt(1'b0, 2, 1'b0, 0);
      add_pkt(1'b1, 2, 1'b0, 0);
    end
    drain();
    checkOutput("contention_beats", W'(src_log.size()), W'(16));
    if (src_log.size() == 16) begin
      for (int k = 0; k < 16; k++)
        checkOutput($sformatf("contention_src_%0d", k), W'(src_log[k]), W'((k / 2) % 2));
      checkOutput("contention_no_bubble", W'(cyc_log[15] - cyc_log[0]), W'(15));
    end

    // Backpressure during an in1 packet while in0 waits.
    do_reset();
    ready_pct = 0;
    add_pkt(1'b1, 4, 1'b0, 3);
    applyStimulus();
    add_pkt(1'b0, 2, 1'b0, 1);
    repeat (5) applyStimulus();
    checkOutput("bp_in1_ready_full", W'(i1.ready), '0);
    checkOutput("bp_in0_ready_lock", W'(i0.ready), '0);
    ready_pct = 100;
    drain();

    // Headless beats on in1 while idle are dropped and counted.
    do_reset();
    for (int k = 0; k < 3; k++) add_stray(1'b1);
    drain();
    checkOutput("err_beats", W'(s_err), W'(3));
    checkOutput("err_out_pkt", W'(s_out), '0);

    // Asynchronous reset in the middle of a 5-beat in0 packet.
    do_reset();
    add_pkt(1'b0, 5, 1'b0, 0);
    for (int n = 0; n < 20 && q0.size() > 3; n++) applyStimulus();
    checkOutput("midrst_progress", W'(q0.size()), W'(3));
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    checkOutput("midrst_out_valid", W'(o.valid), '0);
    checkOutput("midrst_stats", W'({s_in0, s_in1, s_out, s_err}), '0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    add_pkt(1'b1, 1, 1'b0, 7);
    drain();
    checkOutput("midrst_in1_pkt", W'(s_in1), W'(1));

    // Random traffic with gaps, backpressure and protocol errors.
    do_reset();
    gap_pct = 30; ready_pct = 70;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0 && q0.size() < 24) begin
        if ($urandom_range(0, 5) == 0) add_stray(1'b0);
        else add_pkt(1'b0, $urandom_range(1, 6), 1'b1, $urandom_range(0, 63));
      end
      if ($urandom_range(0, 7) == 0 && q1.size() < 24) begin
        if ($urandom_range(0, 5) == 0) add_stray(1'b1);
        else add_pkt(1'b1, $urandom_range(1, 6), 1'b1, $urandom_range(0, 63));
      end
      applyStimulus();
    end
    drain();

    // Counter wrap on the egress packet count.
    gap_pct = 0; ready_pct = 100;
    @(negedge clk);
    force dut.stats_out_pkt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stats_out_pkt_q;
    m_out = 32'hFFFF_FFFF;
    add_pkt(1'b0, 1, 1'b0, 0);
    drain();
    checkOutput("wrap_out_pkt", W'(s_out), '0);

    checkOutput("scoreboard_empty", W'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
